rand_arbiter: RTL and testbench
===============================

RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter NBITS, default 8, giving the width of each random word and the number of LFSR shifts per grant (1..16).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: synchronous, active-low reset, sampled on the CLK rising edge.
REQ-005 The block SHALL have port REQ, input, NREQ bits: level request, one bit per requester.
REQ-006 The block SHALL have port ACK, output, NREQ bits: one-hot, one-cycle pulse marking DATA valid for that requester.
REQ-007 The block SHALL have port DATA, output, NBITS bits: registered random word, held until the next ACK.
REQ-008 The block SHALL have port BUSY, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-009 The block SHALL have port SEED_LD, input, 1 bit: single-cycle reseed strobe.
REQ-010 The block SHALL have port SEED_IN, input, 32 bits: reseed value, sampled when SEED_LD=1.

Function
REQ-011 The block SHALL contain a 32-bit LFSR with shift r <= {r[30:0], ~(r[31]^r[21]^r[1]^r[0])} and default seed 32'h6B1CCA14.
REQ-012 The LFSR SHALL shift only in state SHIFT and SHALL hold its value in every other state.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 In IDLE with any REQ bit high, the FSM SHALL latch the winner index, load the shift counter with NBITS-1 and go to SHIFT; with REQ=0 it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: the search starts at (last_grant+1) mod NREQ and the first set REQ bit wins.
REQ-016 last_grant SHALL update only when DONE is entered.
REQ-017 SHIFT SHALL last exactly NBITS cycles, one LFSR shift per cycle, then go to DONE.
REQ-018 On the edge entering DONE, DATA SHALL load the post-shift LFSR bits [NBITS-1:0].
REQ-019 In DONE, ACK[winner] SHALL be 1 for exactly one cycle and all other ACK bits 0; the next state SHALL be IDLE.
REQ-020 Latency: REQ sampled high in IDLE at edge k SHALL give ACK high in the cycle after edge k+NBITS+1.
REQ-021 A requester SHALL drop REQ by the edge ending its ACK cycle; a REQ still high in the following IDLE SHALL be treated as a new request.
REQ-022 REQ changes during SHIFT/DONE SHALL NOT affect the current grant; a winner dropping REQ mid-SHIFT SHALL still receive ACK.
REQ-023 SEED_LD=1 SHALL have priority in any state: LFSR <= SEED_IN, FSM -> IDLE, any in-progress grant is aborted without ACK, and last_grant and DATA are unchanged.
REQ-024 A SEED_IN of 32'hFFFFFFFF (the XNOR lock-up state) SHALL be replaced by 32'h6B1CCA14.
REQ-025 SEED_LD and RST_N=0 in the same cycle SHALL resolve to reset.

Reset
REQ-026 When RST_N=0 at an edge, the block SHALL set LFSR=32'h6B1CCA14, FSM=IDLE, last_grant=NREQ-1, DATA=0, ACK=0 and BUSY=0.
REQ-027 Reset SHALL take effect in any state, including mid-SHIFT, and SHALL suppress any pending ACK.

Verification
REQ-028 Reset, then REQ=4'b0001 held until ACK -> BUSY high from the next cycle; ACK=4'b0001 9 cycles after the sampling edge; DATA=8'h84; LFSR=32'h1CCA1484.
REQ-029 REQ=4'b1111 held, each requester dropping REQ after its ACK -> ACK order 0,1,2,3, each ACK 10 cycles apart (1 IDLE + 8 SHIFT + 1 DONE).
REQ-030 SEED_LD with SEED_IN=32'h00000001 on the 4th SHIFT cycle -> no ACK, FSM in IDLE next cycle, LFSR=32'h00000001; a re-request yields DATA taken from the new seed sequence.
REQ-031 SEED_LD with SEED_IN=32'hFFFFFFFF, then REQ=4'b0001 -> DATA=8'h84, the same as after reset.
REQ-032 RST_N=0 asserted mid-SHIFT with REQ=4'b0100 -> no ACK; after release ACK[2] arrives with DATA=8'h84.
REQ-033 Winner drops REQ on the 2nd SHIFT cycle while REQ=4'b0011 -> ACK still goes to the original winner; the other requester is served next.

Source files
------------

// File: rtl/rand_arbiter.sv
// Round-robin arbiter that hands each winner a fresh NBITS-bit word from an LFSR.
// Ports: CLK, RST_N (sync, active-low), REQ/ACK per requester, DATA, BUSY, SEED_LD/SEED_IN.
module rand_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [NREQ-1:0]  REQ,
  output logic [NREQ-1:0]  ACK,
  output logic [NBITS-1:0] DATA,
  output logic             BUSY,
  input  logic             SEED_LD,
  input  logic [31:0]      SEED_IN
);

  localparam int IW = $clog2(NREQ);
  localparam logic [31:0] SEED_DEF = 32'h6B1CCA14;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [IW-1:0]    last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [NBITS-1:0] data_q, data_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [IW-1:0]    pick;
  logic [31:0]      lfsr_nxt;

  // XNOR feedback: all-ones is the lock-up state.
  assign lfsr_nxt = {lfsr_q[30:0],
                     ~(lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0])};

  // Search starts one past the last winner and wraps.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && REQ[IW'((int'(last_q) + i) % NREQ)]) begin
        found = 1'b1;
        pick  = IW'((int'(last_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ack_d   = '0;
    if (SEED_LD) begin
      // Abort any grant; never load the lock-up value.
      state_d = IDLE;
      lfsr_d  = (SEED_IN == 32'hFFFF_FFFF) ? SEED_DEF : SEED_IN;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            win_d   = pick;
            cnt_d   = 4'(NBITS - 1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          lfsr_d = lfsr_nxt;
          if (cnt_q == 4'd0) begin
            state_d = DONE;
            data_d  = lfsr_nxt[NBITS-1:0];
            last_d  = win_q;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DONE: begin
          ack_d[win_q] = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_DEF;
      win_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ACK  = ack_q;
  assign DATA = data_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// Bench for rand_arbiter: directed table, corner sequences, random run.
// A transaction-level model predicts ACK/DATA/BUSY every cycle.
module tb_rand_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam logic [31:0] DEF = 32'h6B1CCA14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             seed_ld;
  logic [31:0]      seed_in;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  ack;
  logic [NBITS-1:0] data;
  logic             busy;

  rand_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .REQ    (req),
    .ACK    (ack),
    .DATA   (data),
    .BUSY   (busy),
    .SEED_LD(seed_ld),
    .SEED_IN(seed_in)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: m_cnt counts remaining busy cycles (SHIFT + DONE), 0 = idle.
  int               m_cnt  = 0;
  int               m_win  = 0;
  int               m_last = NREQ - 1;
  logic [31:0]      m_lfsr = DEF;
  logic [NBITS-1:0] m_data = '0;
  logic [NREQ-1:0]  m_ack  = '0;

  function automatic logic [31:0] adv(input logic [31:0] r, input int n);
    for (int i = 0; i < n; i++)
      r = {r[30:0], ~(r[31] ^ r[21] ^ r[1] ^ r[0])};
    return r;
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++)
      if (r[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  task automatic model_step();
    m_ack = '0;
    if (!rst_n) begin
      m_lfsr = DEF;
      m_cnt  = 0;
      m_last = NREQ - 1;
      m_data = '0;
    end else if (seed_ld) begin
      m_lfsr = (seed_in == 32'hFFFF_FFFF) ? DEF : seed_in;
      m_cnt  = 0;
    end else if (m_cnt == 0) begin
      if (req != '0) begin
        m_win = rr_pick(m_last, req);
        m_cnt = NBITS + 1;
      end
    end else begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 1) begin
        m_lfsr = adv(m_lfsr, NBITS);
        m_data = m_lfsr[NBITS-1:0];
        m_last = m_win;
      end else if (m_cnt == 0) begin
        m_ack[m_win] = 1'b1;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("ack", 32'(ack), 32'(m_ack));
    check("data", 32'(data), 32'(m_data));
    check("busy", 32'(busy), 32'(m_cnt != 0));
    if (m_cnt <= 1) check("lfsr", dut.lfsr_q, m_lfsr);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == '0 && n < 100);
    if (ack == '0) check("ack_timeout", 32'(n), 32'(NBITS + 2));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  exp_ack;
    bit               chk_data;
    logic [NBITS-1:0] exp_data;
  } vec_t;

  vec_t tbl[8];
  int   n;

  initial begin
    tbl[0] = '{4'b0001, 4'b0001, 1'b1, 8'h84};
    tbl[1] = '{4'b1111, 4'b0010, 1'b0, 8'h00};
    tbl[2] = '{4'b1001, 4'b1000, 1'b0, 8'h00};
    tbl[3] = '{4'b0111, 4'b0001, 1'b0, 8'h00};
    tbl[4] = '{4'b0100, 4'b0100, 1'b0, 8'h00};
    tbl[5] = '{4'b0110, 4'b0010, 1'b0, 8'h00};
    tbl[6] = '{4'b1000, 4'b1000, 1'b0, 8'h00};
    tbl[7] = '{4'b1000, 4'b1000, 1'b0, 8'h00};

    rst_n   = 1'b0;
    seed_ld = 1'b0;
    seed_in = '0;
    req     = '0;
    do_reset();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_lfsr", dut.lfsr_q, DEF);

    // Directed round-robin table, each request held until its ACK.
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      wait_ack(n);
      check("tbl_ack", 32'(ack), 32'(tbl[i].exp_ack));
      check("tbl_lat", 32'(n), 32'(NBITS + 2));
      if (tbl[i].chk_data) check("tbl_data", 32'(data), 32'(tbl[i].exp_data));
      if (i == 0) check("first_lfsr", dut.lfsr_q, 32'h1CCA1484);
      req = '0;
    end
    tick();

    // All four requesting: served 0,1,2,3 at fixed spacing.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      wait_ack(n);
      check("rr_order", 32'(ack), 32'(1) << i);
      check("rr_gap", 32'(n), 32'(NBITS + 2));
      req = req & ~ack;
    end
    tick();

    // Reseed on the 4th SHIFT cycle aborts the grant.
    do_reset();
    req = 4'b0001;
    tick();
    check("busy_after_sample", 32'(busy), 32'h1);
    repeat (3) tick();
    seed_ld = 1'b1;
    seed_in = 32'h0000_0001;
    tick();
    seed_ld = 1'b0;
    req     = '0;
    check("seed_busy", 32'(busy), 32'h0);
    check("seed_lfsr", dut.lfsr_q, 32'h0000_0001);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("seed_no_ack", 32'(ack), 32'h0);
    end
    req = 4'b0001;
    wait_ack(n);
    check("seed_data", 32'(data), 32'h24);
    check("seed_lfsr2", dut.lfsr_q, 32'h0000_0124);
    req = '0;

    // All-ones seed falls back to the default seed.
    seed_ld = 1'b1;
    seed_in = 32'hFFFF_FFFF;
    tick();
    seed_ld = 1'b0;
    check("lockup_lfsr", dut.lfsr_q, DEF);
    req = 4'b0001;
    wait_ack(n);
    check("lockup_data", 32'(data), 32'h84);
    req = '0;
    tick();

    // Reset mid-SHIFT suppresses the ACK.
    do_reset();
    req = 4'b0100;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_ack", 32'(ack), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    wait_ack(n);
    check("rst_mid_grant", 32'(ack), 32'h4);
    check("rst_mid_data", 32'(data), 32'h84);
    req = '0;
    tick();

    // Winner drops REQ mid-SHIFT and is still served.
    do_reset();
    req = 4'b0011;
    tick();
    tick();
    req = 4'b0010;
    wait_ack(n);
    check("drop_ack", 32'(ack), 32'h1);
    wait_ack(n);
    check("drop_next", 32'(ack), 32'h2);
    req = '0;
    tick();

    // Reset wins over a simultaneous reseed.
    seed_ld = 1'b1;
    seed_in = 32'h0000_0001;
    rst_n   = 1'b0;
    tick();
    check("rst_seed_lfsr", dut.lfsr_q, DEF);
    seed_ld = 1'b0;
    rst_n   = 1'b1;

    // Random traffic with occasional reseeds and resets.
    do_reset();
    repeat (800) begin
      req     = NREQ'($urandom);
      seed_ld = ($urandom_range(0, 39) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rst_n   = ($urandom_range(0, 149) != 0);
      tick();
    end
    seed_ld = 1'b0;
    rst_n   = 1'b1;
    req     = '0;
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
